frame_reader: RTL and testbench

- Read-side companion to the pixel capture path. On trigger, fetches a stored frame from DDR through the MIG read request/ack/data interface in 256-bit bursts.
- Pushes the returned words into a downstream output buffer FIFO that is drained by the host pipe.
- Credit-based issue logic ensures read data can never overflow the output buffer.

---
 rtl/frame_reader_if.sv | 22 ++
 rtl/frame_reader.sv | 110 +++++++++++
 tb/tb_frame_reader.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_reader_if.sv
// rtl/frame_reader_if.sv - MIG read port and output FIFO write port bundle
interface frame_reader_if;
  logic         mem_rd_req;
  logic [28:0]  mem_rd_addr;
  logic         mem_rd_ack;
  logic         mem_rd_data_valid;
  logic [255:0] mem_rd_data;
  logic         ob_wr_en;
  logic [255:0] ob_din;
  logic [8:0]   ob_count;
  logic         ob_full;

  modport master (
    output mem_rd_req, mem_rd_addr, ob_wr_en, ob_din,
    input  mem_rd_ack, mem_rd_data_valid, mem_rd_data, ob_count, ob_full
  );

  modport slave (
    input  mem_rd_req, mem_rd_addr, ob_wr_en, ob_din,
    output mem_rd_ack, mem_rd_data_valid, mem_rd_data, ob_count, ob_full
  );
endinterface

// File: rtl/frame_reader.sv
// rtl/frame_reader.sv - credit-gated DDR frame fetch into the output FIFO
module frame_reader #(
  parameter int OB_DEPTH          = 256,
  parameter int MAX_OUTSTANDING   = 16,
  parameter int ADDRESS_INCREMENT = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 trigger,
  input  logic [29:0]          start_addr,
  input  logic [23:0]          burst_count,
  output logic                 busy,
  output logic                 frame_read,
  output logic                 overflow,
  frame_reader_if.master       mem
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t      state;
  logic [23:0] remaining;
  logic [4:0]  outstanding;
  logic [9:0]  credit_sum;
  logic        can_issue;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = start_addr[0];

  // Words sitting in the data register still count as outstanding until written.
  assign credit_sum = {1'b0, mem.ob_count} + {5'b0, outstanding};
  assign can_issue  = (credit_sum < 10'(OB_DEPTH)) &&
                      (outstanding < 5'(MAX_OUTSTANDING));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem.ob_wr_en <= 1'b0;
      mem.ob_din   <= '0;
      overflow     <= 1'b0;
    end else begin
      mem.ob_wr_en <= mem.mem_rd_data_valid;
      mem.ob_din   <= mem.mem_rd_data;
      overflow     <= mem.mem_rd_data_valid && mem.ob_full;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      outstanding <= '0;
    end else begin
      case ({mem.mem_rd_ack, mem.ob_wr_en})
        2'b10:   outstanding <= outstanding + 5'd1;
        2'b01:   if (outstanding != 5'd0) outstanding <= outstanding - 5'd1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= S_IDLE;
      busy            <= 1'b0;
      frame_read      <= 1'b0;
      mem.mem_rd_req  <= 1'b0;
      mem.mem_rd_addr <= '0;
      remaining       <= '0;
    end else begin
      frame_read <= 1'b0;
      case (state)
        S_IDLE: begin
          if (trigger) begin
            mem.mem_rd_addr <= start_addr[29:1];
            remaining       <= burst_count;
            busy            <= 1'b1;
            state           <= (burst_count == 24'd0) ? S_DONE : S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (can_issue && !mem.mem_rd_ack) begin
            mem.mem_rd_req <= 1'b1;
            state          <= S_WAIT_ACK;
          end
        end
        S_WAIT_ACK: begin
          if (mem.mem_rd_ack) begin
            mem.mem_rd_req  <= 1'b0;
            mem.mem_rd_addr <= mem.mem_rd_addr + 29'(ADDRESS_INCREMENT);
            remaining       <= remaining - 24'd1;
            state           <= (remaining == 24'd1) ? S_DRAIN : S_ISSUE;
          end
        end
        S_DRAIN: begin
          if ((outstanding == 5'd0) && !mem.ob_wr_en) state <= S_DONE;
        end
        S_DONE: begin
          frame_read <= 1'b1;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_reader.sv
// tb/tb_frame_reader.sv - scoreboard bench for frame_reader with a MIG responder model
module tb_frame_reader;

  typedef struct {
    int           ready;
    logic [255:0] d;
  } pend_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         trigger = 1'b0;
  logic [29:0]  start_addr = '0;
  logic [23:0]  burst_count = '0;
  logic         busy;
  logic         frame_read;
  logic         overflow;

  frame_reader_if mem();

  frame_reader #(
    .OB_DEPTH(256),
    .MAX_OUTSTANDING(16),
    .ADDRESS_INCREMENT(8)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .trigger(trigger),
    .start_addr(start_addr),
    .burst_count(burst_count),
    .busy(busy),
    .frame_read(frame_read),
    .overflow(overflow),
    .mem(mem)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int acks = 0;
  int writes = 0;
  int frames = 0;
  int ovfs = 0;
  int ret_count = 0;
  int ret_limit = 1000000;
  int full_on_ret = -1;

  logic [28:0]  exp_addr_q[$];
  logic [255:0] exp_data_q[$];
  pend_t        pend_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // MIG responder and output-side monitor, all on the falling edge
  initial begin : model
    bit    req_seen;
    bit    prev_valid;
    int    full_hold;
    pend_t p;
    req_seen   = 0;
    prev_valid = 0;
    full_hold  = 0;
    mem.mem_rd_ack        = 1'b0;
    mem.mem_rd_data_valid = 1'b0;
    mem.mem_rd_data       = '0;
    mem.ob_full           = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        mem.mem_rd_ack        = 1'b0;
        mem.mem_rd_data_valid = 1'b0;
        mem.ob_full           = 1'b0;
        req_seen   = 0;
        prev_valid = 0;
        full_hold  = 0;
        exp_addr_q.delete();
        exp_data_q.delete();
        pend_q.delete();
      end else begin
        if (prev_valid || mem.ob_wr_en) check("wr_latency", mem.ob_wr_en, prev_valid);
        if (mem.ob_wr_en) begin
          writes++;
          if (exp_data_q.size() == 0) check("wr_unexpected", 1, 0);
          else check("ob_din", mem.ob_din, exp_data_q.pop_front());
        end
        if (overflow) begin
          ovfs++;
          check("ovf_with_wr", mem.ob_wr_en, 1);
        end
        if (frame_read) frames++;

        if (mem.mem_rd_ack) begin
          mem.mem_rd_ack = 1'b0;
          req_seen = 0;
        end else if (mem.mem_rd_req) begin
          if (!req_seen) begin
            req_seen = 1;
          end else begin
            mem.mem_rd_ack = 1'b1;
            acks++;
            if (exp_addr_q.size() == 0) check("addr_unexpected", 1, 0);
            else check("rd_addr", mem.mem_rd_addr, exp_addr_q.pop_front());
            p.ready = cyc + 3;
            p.d     = rand256();
            pend_q.push_back(p);
          end
        end

        if (full_hold > 0) full_hold--;
        mem.mem_rd_data_valid = 1'b0;
        if (ret_count < ret_limit && pend_q.size() > 0 && cyc >= pend_q[0].ready) begin
          p = pend_q.pop_front();
          mem.mem_rd_data_valid = 1'b1;
          mem.mem_rd_data       = p.d;
          exp_data_q.push_back(p.d);
          if (ret_count == full_on_ret) full_hold = 1;
          ret_count++;
        end
        mem.ob_full = (full_hold > 0);
        prev_valid  = mem.mem_rd_data_valid;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic start_frame(input logic [29:0] a, input logic [23:0] n);
    logic [28:0] base;
    base        = a[29:1];
    start_addr  = a;
    burst_count = n;
    trigger     = 1'b1;
    for (int i = 0; i < int'(n); i++) exp_addr_q.push_back(base + 29'(8 * i));
    tick();
    trigger = 1'b0;
  endtask

  task automatic wait_frame(input string tag, input int f0);
    int k;
    k = 0;
    while (frames == f0 && k < 2000) begin
      tick();
      k++;
    end
    check(tag, frames, f0 + 1);
  endtask

  task automatic check_idle_clean(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_addrq"}, exp_addr_q.size(), 0);
    check({tag, "_dataq"}, exp_data_q.size(), 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin : main
    int a0;
    int w0;
    int f0;
    int o0;
    int k;
    mem.ob_count = 9'd0;
    ticks(3);

    check("rst_busy", busy, 0);
    check("rst_frame_read", frame_read, 0);
    check("rst_overflow", overflow, 0);
    check("rst_req", mem.mem_rd_req, 0);
    check("rst_wr_en", mem.ob_wr_en, 0);
    check("rst_addr", mem.mem_rd_addr, 0);
    check("rst_din", mem.ob_din, 0);
    reset_n = 1'b1;
    ticks(2);

    // basic 4-burst read
    a0 = acks; w0 = writes; f0 = frames;
    start_frame(30'h100, 24'd4);
    check("basic_busy", busy, 1);
    wait_frame("basic_frame", f0);
    check("basic_acks", acks, a0 + 4);
    check("basic_writes", writes, w0 + 4);
    ticks(3);
    check("basic_one_pulse", frames, f0 + 1);
    check("basic_no_ovf", ovfs, 0);
    check_idle_clean("basic");

    // output FIFO backpressure via ob_count
    a0 = acks; f0 = frames;
    mem.ob_count = 9'd250;
    ret_limit = ret_count;
    start_frame(30'h1000, 24'd20);
    ticks(60);
    check("bp_acks", acks, a0 + 6);
    check("bp_req_low", mem.mem_rd_req, 0);
    mem.ob_count = 9'd0;
    ret_limit = 1000000;
    wait_frame("bp_frame", f0);
    check("bp_acks_all", acks, a0 + 20);
    check_idle_clean("bp");

    // outstanding limit
    a0 = acks; f0 = frames;
    ret_limit = ret_count;
    start_frame(30'h8000, 24'd40);
    ticks(100);
    check("os_acks", acks, a0 + 16);
    check("os_req_low", mem.mem_rd_req, 0);
    ret_limit = ret_count + 1;
    ticks(20);
    check("os_one_more", acks, a0 + 17);
    ret_limit = 1000000;
    wait_frame("os_frame", f0);
    check("os_acks_all", acks, a0 + 40);
    check_idle_clean("os");

    // zero-length frame
    a0 = acks; f0 = frames;
    start_frame(30'h2222, 24'd0);
    check("zl_busy", busy, 1);
    check("zl_fr_early", frame_read, 0);
    tick();
    check("zl_fr", frame_read, 1);
    tick();
    check("zl_fr_gone", frame_read, 0);
    check("zl_no_req", acks, a0);
    check_idle_clean("zl");

    // retrigger while busy is ignored
    a0 = acks; f0 = frames;
    start_frame(30'h2000, 24'd10);
    ticks(8);
    start_addr  = 30'h3000;
    burst_count = 24'd5;
    trigger     = 1'b1;
    tick();
    trigger = 1'b0;
    wait_frame("rt_frame", f0);
    ticks(40);
    check("rt_acks", acks, a0 + 10);
    check("rt_frames", frames, f0 + 1);
    check_idle_clean("rt");

    // overflow on one data return
    a0 = acks; f0 = frames; o0 = ovfs; w0 = writes;
    full_on_ret = ret_count + 1;
    start_frame(30'h5000, 24'd4);
    wait_frame("ovf_frame", f0);
    check("ovf_count", ovfs, o0 + 1);
    check("ovf_writes", writes, w0 + 4);
    full_on_ret = -1;
    check_idle_clean("ovf");

    // asynchronous reset mid-frame
    a0 = acks;
    start_frame(30'h4000, 24'd8);
    k = 0;
    while (acks < a0 + 3 && k < 500) begin
      tick();
      k++;
    end
    check("ar_reached3", acks, a0 + 3);
    tick();
    check("ar_busy_before", busy, 1);
    reset_n = 1'b0;
    #1;
    check("ar_busy", busy, 0);
    check("ar_req", mem.mem_rd_req, 0);
    check("ar_addr", mem.mem_rd_addr, 0);
    check("ar_wr_en", mem.ob_wr_en, 0);
    check("ar_din", mem.ob_din, 0);
    check("ar_frame_read", frame_read, 0);
    check("ar_overflow", overflow, 0);
    ticks(3);
    reset_n = 1'b1;
    tick();
    a0 = acks; f0 = frames;
    start_frame(30'h6000, 24'd2);
    wait_frame("ar_new_frame", f0);
    check("ar_new_acks", acks, a0 + 2);
    check_idle_clean("ar");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
